// File: rtl/prog_sequencer.sv
// Run controller: holds the core in reset, releases it, counts RUN cycles until
// core_done, and steps through NPROG programs. Optional macro SEQ_STEP_EN adds step_go_i.
module prog_sequencer #(
  parameter int          NPROG   = 3,
  parameter int          PSW     = 2,
  parameter int          CW      = 16,
  parameter int          RST_CYC = 2,
  parameter int unsigned TIMEOUT = 16'hFFFF
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           start_i,
  input  logic           core_done_i,
`ifdef SEQ_STEP_EN
  input  logic           step_go_i,
`endif
  output logic           core_reset_o,
  output logic [PSW-1:0] prog_sel_o,
  output logic           busy_o,
  output logic           all_done_o,
  output logic [CW-1:0]  cyc_cnt_o,
  output logic           cyc_valid_o,
  output logic           timeout_o
);

  localparam int HW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [HW-1:0]  HOLD_LAST = HW'(RST_CYC - 1);
  localparam logic [PSW-1:0] PROG_LAST = PSW'(NPROG - 1);
  localparam logic [CW-1:0]  CNT_MAX   = CW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, HOLD, RUN, NEXT, FINISH} state_t;

  state_t         state_q, state_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [PSW-1:0] prog_q, prog_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           to_q, to_d;
  logic           core_reset_q, core_reset_d;
  logic           busy_q, busy_d;
  logic           all_done_q, all_done_d;
  logic           valid_q, valid_d;
  logic           step_ok;

`ifdef SEQ_STEP_EN
  assign step_ok = step_go_i;
`else
  assign step_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    prog_d  = prog_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    case (state_q)
      IDLE, FINISH: begin
        if (start_i) begin
          state_d = HOLD;
          hold_d  = '0;
          prog_d  = '0;
          to_d    = 1'b0;
        end
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RUN: begin
        // done wins over a simultaneous limit hit, so timeout stays clear
        if (core_done_i) begin
          state_d = NEXT;
        end else if (cnt_q == CNT_MAX) begin
          state_d = NEXT;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      NEXT: begin
        if (step_ok) begin
          if (prog_q == PROG_LAST) begin
            state_d = FINISH;
          end else begin
            state_d = HOLD;
            prog_d  = prog_q + 1'b1;
            hold_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    core_reset_d = (state_d != RUN);
    busy_d       = (state_d == HOLD) || (state_d == RUN) || (state_d == NEXT);
    all_done_d   = (state_d == FINISH);
    // pulse only on NEXT entry, so a held NEXT reports each count once
    valid_d      = (state_d == NEXT) && (state_q != NEXT);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      prog_q       <= '0;
      cnt_q        <= '0;
      to_q         <= 1'b0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      all_done_q   <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      prog_q       <= prog_d;
      cnt_q        <= cnt_d;
      to_q         <= to_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
      all_done_q   <= all_done_d;
      valid_q      <= valid_d;
    end
  end

  assign core_reset_o = core_reset_q;
  assign prog_sel_o   = prog_q;
  assign busy_o       = busy_q;
  assign all_done_o   = all_done_q;
  assign cyc_cnt_o    = cnt_q;
  assign cyc_valid_o  = valid_q;
  assign timeout_o    = to_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: table vectors, randomized program lengths against a
// cycle-trace model, plus hand sequences for reset abort and step mode.
module tb_prog_sequencer;
  localparam int NPROG = 3;
  localparam int PSW   = 2;
  localparam int CW    = 16;
  localparam int RST   = 2;
  localparam int TO    = 20;

  logic           clk = 1'b0;
  logic           reset, start, core_done;
  logic           core_reset, busy, all_done, cyc_valid, timeout;
  logic [PSW-1:0] prog_sel;
  logic [CW-1:0]  cyc_cnt;
`ifdef SEQ_STEP_EN
  logic           step_go;
`endif

  prog_sequencer #(.NPROG(NPROG), .PSW(PSW), .CW(CW), .RST_CYC(RST), .TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .core_done_i(core_done),
`ifdef SEQ_STEP_EN
    .step_go_i(step_go),
`endif
    .core_reset_o(core_reset), .prog_sel_o(prog_sel), .busy_o(busy),
    .all_done_o(all_done), .cyc_cnt_o(cyc_cnt), .cyc_valid_o(cyc_valid),
    .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef int lens_t[NPROG];
  typedef struct {
    bit cr, bsy, alld, vld, to;
    int prog, cnt;
    bit cnt_chk;
    int run_idx;
  } exp_t;
  typedef struct {
    lens_t lens;
    lens_t exp_cnt;
    bit    exp_to;
  } vec_t;

  exp_t q[$];
  int   obs_cnt[NPROG];

  function automatic exp_t mk(bit cr, bit bsy, bit alld, bit vld, bit to,
                              int prog, int cnt, bit cc, int ri);
    exp_t e;
    e.cr = cr; e.bsy = bsy; e.alld = alld; e.vld = vld; e.to = to;
    e.prog = prog; e.cnt = cnt; e.cnt_chk = cc; e.run_idx = ri;
    return e;
  endfunction

  // Expected per-cycle trace: RST hold cycles, min(L,TO)+1 run cycles, one NEXT cycle per program.
  task automatic build_model(input lens_t lens);
    bit to_s = 0;
    int c = 0;
    q.delete();
    for (int p = 0; p < NPROG; p++) begin
      for (int h = 0; h < RST; h++) q.push_back(mk(1, 1, 0, 0, to_s, p, 0, 0, -1));
      c = (lens[p] > TO) ? TO : lens[p];
      for (int i = 0; i <= c; i++) q.push_back(mk(0, 1, 0, 0, to_s, p, i, 1, i));
      if (lens[p] > TO) to_s = 1;
      q.push_back(mk(1, 1, 0, 1, to_s, p, c, 1, -1));
    end
    q.push_back(mk(1, 0, 1, 0, to_s, NPROG - 1, c, 1, -1));
  endtask

  task automatic run_seq(input lens_t lens, input string tag);
    int pc = 0;
    exp_t e;
    build_model(lens);
    @(negedge clk);
    start = 1'b1;
    core_done = 1'($urandom_range(0, 1));
`ifdef SEQ_STEP_EN
    step_go = 1'b1;
`endif
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      e = q[k];
      chk({tag, " ctl"}, {core_reset, busy, all_done, cyc_valid, timeout, prog_sel},
          {e.cr, e.bsy, e.alld, e.vld, e.to, PSW'(e.prog)});
      if (e.cnt_chk) chk({tag, " cnt"}, cyc_cnt, e.cnt);
      if (cyc_valid === 1'b1 && pc < NPROG) begin
        obs_cnt[pc] = int'(cyc_cnt);
        pc++;
      end
      // noise on start and core_done where the design must ignore them
      start = (k == q.size() - 1) ? 1'b0 : 1'($urandom_range(0, 3) == 0);
      core_done = (e.run_idx >= 0) ? (e.run_idx == lens[e.prog]) : 1'($urandom_range(0, 1));
    end
    chk({tag, " pulses"}, pc, NPROG);
  endtask

  vec_t tbl[5];
  lens_t rl, ec;
  int wait_n;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0].lens = '{10, 10, 10}; tbl[0].exp_cnt = '{10, 10, 10}; tbl[0].exp_to = 0;
    tbl[1].lens = '{0, 5, 0};    tbl[1].exp_cnt = '{0, 5, 0};    tbl[1].exp_to = 0;
    tbl[2].lens = '{25, 3, 40};  tbl[2].exp_cnt = '{20, 3, 20};  tbl[2].exp_to = 1;
    tbl[3].lens = '{20, 21, 1};  tbl[3].exp_cnt = '{20, 20, 1};  tbl[3].exp_to = 1;
    tbl[4].lens = '{19, 0, 20};  tbl[4].exp_cnt = '{19, 0, 20};  tbl[4].exp_to = 0;

    reset = 1'b1; start = 1'b0; core_done = 1'b0;
`ifdef SEQ_STEP_EN
    step_go = 1'b1;
`endif
    repeat (2) @(negedge clk);
    chk("reset values", {core_reset, busy, all_done, cyc_valid, timeout, prog_sel, cyc_cnt},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, PSW'(0), CW'(0)});
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle hold", {core_reset, busy, all_done}, 3'b100);

    foreach (tbl[v]) begin
      run_seq(tbl[v].lens, $sformatf("vec%0d", v));
      for (int p = 0; p < NPROG; p++)
        chk($sformatf("vec%0d cnt%0d", v, p), obs_cnt[p], tbl[v].exp_cnt[p]);
      chk($sformatf("vec%0d timeout", v), timeout, tbl[v].exp_to);
    end

    // reset abort in the middle of program 1's RUN
    @(negedge clk); start = 1'b1; core_done = 1'b0;
    @(negedge clk); start = 1'b0;
    wait_n = 0;
    while (!(prog_sel == PSW'(1) && core_reset == 1'b0 && cyc_cnt > 3) && wait_n < 200) begin
      core_done = (prog_sel == PSW'(0) && core_reset == 1'b0 && cyc_cnt == 4);
      @(negedge clk);
      wait_n++;
    end
    chk("abort reached run1", wait_n < 200, 1);
    core_done = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("abort values", {core_reset, busy, all_done, cyc_valid, timeout, prog_sel, cyc_cnt},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, PSW'(0), CW'(0)});
    @(negedge clk); reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort stays idle", {core_reset, busy, all_done, prog_sel}, {3'b100, PSW'(0)});

`ifdef SEQ_STEP_EN
    // step mode: NEXT held until step_go
    @(negedge clk); start = 1'b1; step_go = 1'b0; core_done = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_n = 0;
    while (cyc_valid !== 1'b1 && wait_n < 50) begin @(negedge clk); wait_n++; end
    chk("step first valid", {cyc_valid, prog_sel, cyc_cnt}, {1'b1, PSW'(0), CW'(0)});
    repeat (3) begin
      @(negedge clk);
      chk("step wait", {busy, core_reset, cyc_valid, prog_sel}, {3'b110, PSW'(0)});
    end
    step_go = 1'b1; core_done = 1'b0;
    @(negedge clk);
    chk("step go", {busy, core_reset, cyc_valid, prog_sel}, {3'b110, PSW'(1)});
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
`endif

    for (int r = 0; r < 6; r++) begin
      for (int p = 0; p < NPROG; p++) begin
        rl[p] = int'($urandom_range(0, 26));
        ec[p] = (rl[p] > TO) ? TO : rl[p];
      end
      run_seq(rl, $sformatf("rnd%0d", r));
      for (int p = 0; p < NPROG; p++)
        chk($sformatf("rnd%0d cnt%0d", r, p), obs_cnt[p], ec[p]);
      chk($sformatf("rnd%0d timeout", r), timeout,
          (rl[0] > TO) || (rl[1] > TO) || (rl[2] > TO));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
